// File: rtl/node_feeder.sv
// node_feeder: streams N_INPUTS pixel/weight pairs from two read ports into a
// node MAC through a 2-entry skid FIFO, then hands over the bias word and waits
// (with timeout) for the node result.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for start; bias captured on accept
// S_STREAM   | issuing reads and presenting pairs until the last transfer
// S_BIAS     | presenting captured bias until bias_ready
// S_WAIT_RES | waiting for res_valid, counting toward TIMEOUT
// S_DONE     | one-cycle done pulse, then back to idle
module node_feeder #(
  parameter int N_INPUTS = 784,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int TIMEOUT  = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic [ADDR_W-1:0] img_addr,
  output logic [ADDR_W-1:0] wt_addr,
  output logic              img_rd,
  output logic              wt_rd,
  input  logic [DATA_W-1:0] img_rdata,
  input  logic [DATA_W-1:0] wt_rdata,
  output logic [DATA_W-1:0] x_data,
  output logic [DATA_W-1:0] w_data,
  output logic              pair_valid,
  output logic              pair_last,
  input  logic              pair_ready,
  input  logic [DATA_W-1:0] bias_in,
  output logic [DATA_W-1:0] bias_data,
  output logic              bias_valid,
  input  logic              bias_ready,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic [DATA_W-1:0] node_res,
  output logic              done,
  output logic              err
);

  // one extra bit so the index can reach N_INPUTS == 2**ADDR_W without wrapping
  localparam int IDX_W = ADDR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_STREAM, S_BIAS, S_WAIT_RES, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  pair_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              rd_inflight;
  logic [1:0]        occ;
  logic              wr_ptr, rd_ptr;
  logic [DATA_W-1:0] fx [2];
  logic [DATA_W-1:0] fw [2];
  logic [DATA_W-1:0] bias_q;
  logic              start_acc, pop, last_pop, issue, to_expire;

  assign start_acc  = (state == S_IDLE) && start;
  assign pair_valid = (occ != 2'd0);
  assign x_data     = fx[rd_ptr];
  assign w_data     = fw[rd_ptr];
  assign pop        = pair_valid && pair_ready;
  assign pair_last  = pair_valid && (pair_cnt == IDX_W'(N_INPUTS - 1));
  assign last_pop   = pop && pair_last;
  assign to_expire  = (to_cnt == TO_W'(TIMEOUT - 1));

  // a read may go out only if its data is guaranteed a FIFO slot on return
  assign issue = (state == S_STREAM) &&
                 (({1'b0, occ} + {2'b00, rd_inflight}) < (3'd2 + {2'b00, pop})) &&
                 (rd_idx < IDX_W'(N_INPUTS));

  assign img_rd    = issue;
  assign wt_rd     = issue;
  assign img_addr  = rd_idx[ADDR_W-1:0];
  assign wt_addr   = rd_idx[ADDR_W-1:0];
  assign bias_data = bias_q;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start) state_nxt = S_STREAM;
      S_STREAM:   if (last_pop) state_nxt = S_BIAS;
      S_BIAS:     if (bias_ready) state_nxt = S_WAIT_RES;
      S_WAIT_RES: if (res_valid || to_expire) state_nxt = S_DONE;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    bias_valid = (state == S_BIAS);
  end

  // read index, pair count, timeout counter, bias/result/error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx   <= '0;
      pair_cnt <= '0;
      to_cnt   <= '0;
      bias_q   <= '0;
      node_res <= '0;
      err      <= 1'b0;
    end else if (start_acc) begin
      rd_idx   <= '0;
      pair_cnt <= '0;
      to_cnt   <= '0;
      err      <= 1'b0;
      bias_q   <= bias_in;
    end else begin
      if (issue) rd_idx <= rd_idx + 1'b1;
      if (pop)   pair_cnt <= pair_cnt + 1'b1;
      if (state == S_WAIT_RES) begin
        // a result arriving on the expiry cycle takes priority over the error
        if (res_valid)      node_res <= res_data;
        else if (to_expire) err <= 1'b1;
        else                to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  // 2-entry pair FIFO fed by returning read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_inflight <= 1'b0;
      occ         <= 2'd0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fx[0]       <= '0;
      fx[1]       <= '0;
      fw[0]       <= '0;
      fw[1]       <= '0;
    end else begin
      rd_inflight <= issue;
      if (start_acc) begin
        occ    <= 2'd0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (rd_inflight) begin
          fx[wr_ptr] <= img_rdata;
          fw[wr_ptr] <= wt_rdata;
          wr_ptr     <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        case ({rd_inflight, pop})
          2'b10:   occ <= occ + 2'd1;
          2'b01:   occ <= occ - 2'd1;
          default: occ <= occ;
        endcase
      end
    end
  end

endmodule
